cache_sram_bank: RTL and testbench

- Parametrised single-port cache data bank. Successor to the fixed 64-bit, sim-init-only bank.
- Configurable data width and depth.
- Hardware init/flush sweep, so memory contents after reset are defined in silicon, not only in simulation.
- Req/Gnt handshake with read-valid strobe and optional output register.
- Sits between the cache controller and the tag/data arrays, one instance per way.

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_sram_bank_if.sv | 30 +++
 rtl/cache_sram_array.sv | 26 ++
 rtl/cache_sram_bank.sv | 131 +++++++++++++
 tb/tb_cache_sram_bank.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache data bank and its storage array.
package cache_pkg;

    typedef enum logic {
        INIT,
        READY
    } bank_state_e;

    localparam logic [511:0] DEFAULT_INIT_VALUE = '0;

    function automatic int ben_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/cache_sram_bank_if.sv
// Request/grant bus between the cache controller (master) and one data bank (slave).
interface cache_sram_bank_if
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
);
    localparam int BE_W = ben_width(DATA_WIDTH);

    logic                  Req_SI;
    logic                  Gnt_SO;
    logic                  WrEn_SI;
    logic [BE_W-1:0]       BEn_SI;
    logic [ADDR_WIDTH-1:0] Addr_DI;
    logic [DATA_WIDTH-1:0] WrData_DI;
    logic [DATA_WIDTH-1:0] RdData_DO;
    logic                  RdValid_SO;
    logic                  Flush_SI;
    logic                  InitDone_SO;

    modport master (
        output Req_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI, Flush_SI,
        input  Gnt_SO, RdData_DO, RdValid_SO, InitDone_SO
    );

    modport slave (
        input  Req_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI, Flush_SI,
        output Gnt_SO, RdData_DO, RdValid_SO, InitDone_SO
    );
endinterface

// File: rtl/cache_sram_array.sv
// Plain byte-enabled single-port memory with registered read; no reset on storage
// so it maps directly onto a vendor SRAM macro.
module cache_sram_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DATA_DEPTH = 512,
    parameter int IDX_W      = 9
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic                    re,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/cache_sram_bank.sv
// Cache data bank: init/flush sweep FSM, req/gnt access and read-data pipeline
// wrapped around a swappable byte-enabled storage array.
module cache_sram_bank
    import cache_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_DEPTH = 512,
    parameter int                    OUT_REGS   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DEFAULT_INIT_VALUE)
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    cache_sram_bank_if.slave  bus
);
    localparam int BE_W  = ben_width(DATA_WIDTH);
    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_DEPTH - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("cache_sram_bank: DATA_WIDTH must be a multiple of 8");
    end
    if (DATA_DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("cache_sram_bank: DATA_DEPTH exceeds the address space");
    end
    if ($bits(bus.WrData_DI) != DATA_WIDTH) begin : g_bad_bus
        $error("cache_sram_bank: bus DATA_WIDTH does not match the bank");
    end

    bank_state_e           state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  done;
    logic                  acc, rd_acc, wr_acc, in_range, sweeping;
    logic                  arr_we, arr_re;
    logic [IDX_W-1:0]      arr_addr;
    logic [BE_W-1:0]       arr_be;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata, rd_word;
    logic [OUT_REGS:0]     vld_pipe;
    logic                  zero_q;

    assign sweeping   = (state == INIT);
    assign bus.Gnt_SO = (state == READY) & ~bus.Flush_SI;
    assign acc        = bus.Req_SI & bus.Gnt_SO;
    assign wr_acc     = acc & bus.WrEn_SI;
    assign rd_acc     = acc & ~bus.WrEn_SI;
    assign in_range   = 32'(bus.Addr_DI) < DATA_DEPTH;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state <= INIT;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == LAST) begin
                        state <= READY;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (bus.Flush_SI) begin
                        state <= INIT;
                        cnt   <= '0;
                        done  <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.InitDone_SO = done;

    // The sweep owns the array port while no access can be granted.
    assign arr_we    = sweeping | (wr_acc & in_range);
    assign arr_re    = rd_acc & in_range;
    assign arr_addr  = sweeping ? IDX_W'(cnt) : IDX_W'(bus.Addr_DI);
    assign arr_be    = sweeping ? '1 : bus.BEn_SI;
    assign arr_wdata = sweeping ? INIT_VALUE : bus.WrData_DI;

    cache_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (Clk_CI),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .be    (arr_be),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // zero_q resets high so the unreset array output never leaks onto RdData_DO.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            vld_pipe <= '0;
            zero_q   <= 1'b1;
        end else begin
            vld_pipe <= (vld_pipe << 1) | (OUT_REGS+1)'(rd_acc);
            if (rd_acc) zero_q <= ~in_range;
        end
    end

    assign rd_word        = zero_q ? '0 : arr_rdata;
    assign bus.RdValid_SO = vld_pipe[OUT_REGS];

    if (OUT_REGS == 0) begin : g_no_oreg
        assign bus.RdData_DO = rd_word;
    end else begin : g_oreg
        logic [OUT_REGS-1:0][DATA_WIDTH-1:0] data_q;

        always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
                data_q <= '0;
            end else begin
                if (vld_pipe[0]) data_q[0] <= rd_word;
                for (int s = 1; s < OUT_REGS; s++) begin
                    if (vld_pipe[s]) data_q[s] <= data_q[s-1];
                end
            end
        end

        assign bus.RdData_DO = data_q[OUT_REGS-1];
    end
endmodule

// File: tb/tb_cache_sram_bank.sv
// Scoreboard bench: two banks (OUT_REGS 0 and 1) share one stimulus stream and a
// behavioural memory model; monitors pop expected reads when RdValid_SO pulses.
module tb_cache_sram_bank;
    import cache_pkg::*;

    localparam int DW = 64, AW = 5, DEPTH = 16, NB = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0, failures = 0;

    exp_t          q0[$], q1[$];
    logic [DW-1:0] mem [DEPTH];
    bit            ready;
    int            init_left;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_sram_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0();
    cache_sram_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1();

    cache_sram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH),
                      .OUT_REGS(0), .INIT_VALUE(64'h0))
        dut0 (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus0));

    cache_sram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH),
                      .OUT_REGS(1), .INIT_VALUE(64'h0))
        dut1 (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus1));

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        exp_t e;
        while (q0.size() > 0 && q0[0].due < cyc) begin
            check("rd0_missing", 0, 1);
            void'(q0.pop_front());
        end
        if (bus0.RdValid_SO) begin
            if (q0.size() == 0) check("rd0_spurious", 1, 0);
            else begin
                e = q0.pop_front();
                check("rd0_data", bus0.RdData_DO, e.data);
                check("rd0_cycle", DW'(cyc), DW'(e.due));
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        exp_t e;
        while (q1.size() > 0 && q1[0].due < cyc) begin
            check("rd1_missing", 0, 1);
            void'(q1.pop_front());
        end
        if (bus1.RdValid_SO) begin
            if (q1.size() == 0) check("rd1_spurious", 1, 0);
            else begin
                e = q1.pop_front();
                check("rd1_data", bus1.RdData_DO, e.data);
                check("rd1_cycle", DW'(cyc), DW'(e.due));
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    // One clock of stimulus; entered and left at 1 time unit after a rising edge.
    task automatic step(input bit req, input bit wr, input logic [NB-1:0] be,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd, input bit fl);
        bit            gexp;
        logic [DW-1:0] rexp;
        bus0.Req_SI = req; bus0.WrEn_SI = wr; bus0.BEn_SI = be;
        bus0.Addr_DI = addr; bus0.WrData_DI = wd; bus0.Flush_SI = fl;
        bus1.Req_SI = req; bus1.WrEn_SI = wr; bus1.BEn_SI = be;
        bus1.Addr_DI = addr; bus1.WrData_DI = wd; bus1.Flush_SI = fl;
        @(negedge clk);
        gexp = ready && !fl;
        check("gnt0", DW'(bus0.Gnt_SO), DW'(gexp));
        check("gnt1", DW'(bus1.Gnt_SO), DW'(gexp));
        check("done0", DW'(bus0.InitDone_SO), DW'(ready));
        check("done1", DW'(bus1.InitDone_SO), DW'(ready));
        if (req && gexp) begin
            if (wr) begin
                if (addr < DEPTH)
                    for (int i = 0; i < NB; i++)
                        if (be[i]) mem[addr[3:0]][i*8 +: 8] = wd[i*8 +: 8];
            end else begin
                rexp = (addr < DEPTH) ? mem[addr[3:0]] : '0;
                q0.push_back('{rexp, cyc + 1});
                q1.push_back('{rexp, cyc + 2});
            end
        end
        if (ready && fl) begin
            ready = 0;
            init_left = DEPTH;
            model_clear();
        end else if (!ready) begin
            init_left--;
            if (init_left == 0) ready = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0);
    endtask

    task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        step(1, 1, be, a, d, 0);
    endtask

    task automatic rd_word(input logic [AW-1:0] a);
        step(1, 0, '0, a, '0, 0);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 0;
        q0.delete(); q1.delete();
        ready = 0; init_left = DEPTH;
        model_clear();
        #1;
        check("rst_valid0", DW'(bus0.RdValid_SO), 0);
        check("rst_valid1", DW'(bus1.RdValid_SO), 0);
        check("rst_data0", bus0.RdData_DO, '0);
        check("rst_data1", bus1.RdData_DO, '0);
        check("rst_done0", DW'(bus0.InitDone_SO), 0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.Req_SI = 0; bus0.WrEn_SI = 0; bus0.BEn_SI = '0; bus0.Addr_DI = '0;
        bus0.WrData_DI = '0; bus0.Flush_SI = 0;
        bus1.Req_SI = 0; bus1.WrEn_SI = 0; bus1.BEn_SI = '0; bus1.Addr_DI = '0;
        bus1.WrData_DI = '0; bus1.Flush_SI = 0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Requests during the sweep must never be granted.
        for (int i = 0; i < DEPTH + 2; i++) step(1, 0, '0, AW'(i % DEPTH), '0, 0);
        for (int a = 0; a < DEPTH; a++) rd_word(AW'(a));

        wr_word(3, 64'h1122334455667788, 8'hFF);
        wr_word(3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd_word(3);
        wr_word(7, 64'hDEADBEEFDEADBEEF, 8'h00);
        rd_word(7);

        wr_word(5, 64'h5, 8'hFF);
        rd_word(5);
        for (int a = 0; a < DEPTH; a++) rd_word(AW'(a));

        // Flush with a request in the same cycle; the read before it sees old data.
        for (int a = 0; a < DEPTH; a++) wr_word(AW'(a), {$urandom, $urandom} | 64'h1, 8'hFF);
        rd_word(9);
        step(1, 0, '0, 4, '0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'hFF, AW'(i), 64'hFFFF, (i % 3) == 0);
        idle(2);
        for (int a = 0; a < DEPTH; a++) rd_word(AW'(a));

        wr_word(20, 64'h1234, 8'hFF);
        rd_word(20);
        rd_word(31);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NB'($urandom),
                 AW'($urandom_range(0, 19)), {$urandom, $urandom}, $urandom_range(0, 59) == 0);
        idle(DEPTH + 2);

        // Reset in the middle of a flush sweep, with the counter at 7.
        for (int a = 0; a < DEPTH; a++) wr_word(AW'(a), {$urandom, $urandom} | 64'h1, 8'hFF);
        step(0, 0, '0, '0, '0, 1);
        idle(7);
        do_reset(1);
        idle(DEPTH + 2);
        for (int a = 0; a < DEPTH; a++) rd_word(AW'(a));

        idle(4);
        check("drain0", DW'(q0.size()), 0);
        check("drain1", DW'(q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
